// File: rtl/lr35902_dbg_host.sv
// Host-side initiator for the LR35902 debug UART: sends one command byte 8N1, then decodes the one-byte reply into a debug-state snapshot.
// Latency: 2-cycle input sync, 10*BAUD_DIV-cycle tx frame, reply wait of up to TIMEOUT cycles, outputs valid the cycle after the rx stop sample.
// Backpressure: cmd_ready is low from command acceptance until the FSM returns to IDLE; transmission is held off while cts is high.
module lr35902_dbg_host #(
  parameter int BAUD_DIV = 12,
  parameter int TIMEOUT  = 4096
) (
  input  logic        uart_clk,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_data,
  output logic        cmd_ready,
  output logic        busy,
  output logic        tx,
  input  logic        rx,
  input  logic        cts,
  output logic        resp_valid,
  output logic [3:0]  resp_idx,
  output logic [3:0]  resp_nib,
  output logic        resp_timeout,
  output logic        frame_err,
  output logic [3:0]  snap_status,
  output logic [3:0]  snap_f,
  output logic [7:0]  snap_probe,
  output logic [15:0] snap_pc,
  output logic [15:0] snap_sp
);

  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF     = CW'(BAUD_DIV / 2 - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, HOLD, T_START, T_DATA, T_STOP, WAIT, R_START, R_DATA, R_STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bitn;
  logic [7:0]    sh;
  logic [TW-1:0] tcnt;
  logic          ferr_main;

  logic [1:0]    rx_sync;
  logic [1:0]    cts_sync;
  logic          rx_s;
  logic          cts_s;
  logic          rx_q;

  logic          sh_act;
  logic [CW-1:0] sh_cnt;
  logic [3:0]    sh_bits;
  logic          sh_err;
  logic          stray_ok;

  assign rx_s      = rx_sync[1];
  assign cts_s     = cts_sync[1];
  assign frame_err = ferr_main | sh_err;
  assign stray_ok  = (state == IDLE) || (state == HOLD) || (state == T_START) ||
                     (state == T_DATA) || (state == T_STOP);

  // Two-flop synchronisers for the asynchronous rx/cts lines, plus a delayed rx for edge detection.
  always_ff @(posedge uart_clk or posedge reset) begin
    if (reset) begin
      rx_sync  <= 2'b11;
      cts_sync <= 2'b00;
      rx_q     <= 1'b1;
    end else begin
      rx_sync  <= {rx_sync[0], rx};
      cts_sync <= {cts_sync[0], cts};
      rx_q     <= rx_s;
    end
  end

  // Main command/reply FSM: transmit frame, wait for reply, receive and decode into the snapshot.
  always_ff @(posedge uart_clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      bitn         <= '0;
      sh           <= '0;
      tcnt         <= '0;
      tx           <= 1'b1;
      cmd_ready    <= 1'b1;
      busy         <= 1'b0;
      resp_valid   <= 1'b0;
      resp_idx     <= '0;
      resp_nib     <= '0;
      resp_timeout <= 1'b0;
      ferr_main    <= 1'b0;
      snap_status  <= '0;
      snap_f       <= '0;
      snap_probe   <= '0;
      snap_pc      <= 16'hffff;
      snap_sp      <= 16'hffff;
    end else begin
      resp_valid   <= 1'b0;
      resp_timeout <= 1'b0;
      ferr_main    <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            sh        <= cmd_data;
            state     <= HOLD;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        HOLD: begin
          if (!cts_s) begin
            state <= T_START;
            tx    <= 1'b0;
            cnt   <= '0;
          end
        end
        T_START: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            tx    <= sh[0];
            bitn  <= '0;
            state <= T_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        T_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (bitn == 3'd7) begin
              tx    <= 1'b1;
              state <= T_STOP;
            end else begin
              bitn <= bitn + 3'd1;
              tx   <= sh[1];
              sh   <= {1'b0, sh[7:1]};
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        T_STOP: begin
          if (cnt == BIT_LAST) begin
            state <= WAIT;
            tcnt  <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT: begin
          // A start bit takes priority over an expiring timeout on the same cycle.
          if (!rx_s) begin
            state <= R_START;
            cnt   <= HALF;
          end else if (tcnt == TO_LAST) begin
            resp_timeout <= 1'b1;
            state        <= IDLE;
            cmd_ready    <= 1'b1;
            busy         <= 1'b0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        R_START: begin
          if (cnt == '0) begin
            // rx back high at mid-start is a glitch; keep the timeout count already spent.
            if (rx_s) begin
              state <= WAIT;
            end else begin
              state <= R_DATA;
              cnt   <= BIT_LAST;
              bitn  <= '0;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        R_DATA: begin
          if (cnt == '0) begin
            sh  <= {rx_s, sh[7:1]};
            cnt <= BIT_LAST;
            if (bitn == 3'd7) state <= R_STOP;
            else              bitn  <= bitn + 3'd1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        R_STOP: begin
          if (cnt == '0) begin
            if (rx_s) begin
              resp_valid <= 1'b1;
              resp_idx   <= sh[7:4];
              resp_nib   <= sh[3:0];
              case (sh[7:4])
                4'd0:                   snap_status <= sh[3:0];
                4'd1:                   snap_f      <= sh[3:0];
                4'd2, 4'd3:             snap_probe[{sh[4], 2'b00} +: 4] <= sh[3:0];
                4'd4, 4'd5, 4'd6, 4'd7: snap_pc[{sh[5:4], 2'b00} +: 4]  <= sh[3:0];
                4'd8, 4'd9, 4'd10, 4'd11: snap_sp[{sh[5:4], 2'b00} +: 4] <= sh[3:0];
                default: ;
              endcase
            end else begin
              ferr_main <= 1'b1;
            end
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Shadow sampler: times out unsolicited bytes seen outside the reply window and flags them at their stop sample.
  always_ff @(posedge uart_clk or posedge reset) begin
    if (reset) begin
      sh_act  <= 1'b0;
      sh_cnt  <= '0;
      sh_bits <= '0;
      sh_err  <= 1'b0;
    end else begin
      sh_err <= 1'b0;
      if (!sh_act) begin
        if (stray_ok && rx_q && !rx_s) begin
          sh_act  <= 1'b1;
          sh_cnt  <= HALF;
          sh_bits <= '0;
        end
      end else if (sh_cnt != '0) begin
        sh_cnt <= sh_cnt - 1'b1;
      end else begin
        sh_cnt <= BIT_LAST;
        if (sh_bits == 4'd0 && rx_s) begin
          sh_act <= 1'b0;
        end else if (sh_bits == 4'd9) begin
          sh_act <= 1'b0;
          sh_err <= 1'b1;
        end else begin
          sh_bits <= sh_bits + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lr35902_dbg_host.sv
// Self-checking bench for lr35902_dbg_host: directed table, hand-written corner sequences and random transactions.
// Latency: bench-driven; a device model on rx replies after a variable delay.
// Backpressure: cts is held high for chosen spans to stall transmission.
module tb_lr35902_dbg_host;
  localparam int BD = 12;
  localparam int TO = 4096;

  logic        uart_clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic [7:0]  cmd_data;
  logic        cmd_ready;
  logic        busy;
  logic        tx;
  logic        rx;
  logic        cts;
  logic        resp_valid;
  logic [3:0]  resp_idx;
  logic [3:0]  resp_nib;
  logic        resp_timeout;
  logic        frame_err;
  logic [3:0]  snap_status;
  logic [3:0]  snap_f;
  logic [7:0]  snap_probe;
  logic [15:0] snap_pc;
  logic [15:0] snap_sp;

  lr35902_dbg_host #(.BAUD_DIV(BD), .TIMEOUT(TO)) dut (
    .uart_clk(uart_clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .busy(busy), .tx(tx), .rx(rx), .cts(cts),
    .resp_valid(resp_valid), .resp_idx(resp_idx), .resp_nib(resp_nib),
    .resp_timeout(resp_timeout), .frame_err(frame_err), .snap_status(snap_status),
    .snap_f(snap_f), .snap_probe(snap_probe), .snap_pc(snap_pc), .snap_sp(snap_sp)
  );

  always #5 uart_clk = ~uart_clk;

  int checks = 0;
  int failures = 0;
  int n_valid = 0;
  int n_ferr = 0;
  int n_to = 0;
  logic [3:0] last_idx = '0;
  logic [3:0] last_nib = '0;

  // reference model of the snapshot
  logic [3:0]  m_status, m_f;
  logic [7:0]  m_probe;
  logic [15:0] m_pc, m_sp;

  typedef struct {
    logic [7:0]  cmd;
    int          kind;     // 0 good reply, 1 no reply, 2 bad stop bit
    logic [7:0]  reply;
    int          hold;     // cycles of cts=1 after acceptance
    logic [47:0] exp_snap; // {status, f, probe, pc, sp}
  } vec_t;

  vec_t vecs[12];

  // pulse monitor
  always @(negedge uart_clk) begin
    if (resp_valid) begin
      n_valid++;
      last_idx = resp_idx;
      last_nib = resp_nib;
    end
    if (frame_err) n_ferr++;
    if (resp_timeout) n_to++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] dut_snap();
    return {snap_status, snap_f, snap_probe, snap_pc, snap_sp};
  endfunction

  function automatic logic [47:0] model_snap();
    return {m_status, m_f, m_probe, m_pc, m_sp};
  endfunction

  task automatic model_reset();
    m_status = '0; m_f = '0; m_probe = '0; m_pc = 16'hffff; m_sp = 16'hffff;
  endtask

  // tag selects a field; multi-nibble fields are addressed low nibble first
  task automatic model_apply(input logic [7:0] b);
    int idx;
    int s;
    logic [15:0] n;
    idx = int'(b[7:4]);
    n = {12'h000, b[3:0]};
    if (idx == 0) m_status = b[3:0];
    else if (idx == 1) m_f = b[3:0];
    else if (idx < 4) begin
      s = 4 * (idx - 2);
      m_probe = (m_probe & ~(8'hF << s)) | 8'(n << s);
    end else if (idx < 8) begin
      s = 4 * (idx - 4);
      m_pc = (m_pc & ~(16'hF << s)) | (n << s);
    end else if (idx < 12) begin
      s = 4 * (idx - 8);
      m_sp = (m_sp & ~(16'hF << s)) | (n << s);
    end
  endtask

  // device side: drive one 8N1 byte on rx
  task automatic send_rx(input logic [7:0] b, input logic stopbit);
    @(negedge uart_clk);
    rx = 1'b0;
    repeat (BD) @(negedge uart_clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BD) @(negedge uart_clk);
    end
    rx = stopbit;
    repeat (BD) @(negedge uart_clk);
    rx = 1'b1;
  endtask

  // watch tx for a complete frame, checking every cycle; returns on the last stop-bit cycle
  task automatic capture_tx(input logic [7:0] b);
    int w = 0;
    int errs = 0;
    logic e;
    while (tx !== 1'b0 && w < 400) begin
      @(negedge uart_clk);
      w++;
    end
    chk("tx_start_seen", 64'(w < 400), 64'd1);
    for (int i = 0; i < 10 * BD; i++) begin
      if (i > 0) @(negedge uart_clk);
      if (i < BD) e = 1'b0;
      else if (i < 9 * BD) e = b[3'(i / BD - 1)];
      else e = 1'b1;
      if (tx !== e) errs++;
    end
    chk("tx_frame", 64'(errs), 64'd0);
  endtask

  task automatic run_txn(input logic [7:0] cmd, input int kind, input logic [7:0] reply,
                         input int hold, input int delay);
    int v0, f0, t0, w, l, c;
    logic stayed;
    v0 = n_valid; f0 = n_ferr; t0 = n_to;
    if (hold > 0) begin
      cts = 1'b1;
      repeat (3) @(negedge uart_clk);
    end
    @(negedge uart_clk);
    cmd_valid = 1'b1;
    cmd_data = cmd;
    w = 0;
    while (!cmd_ready && w < 100) begin
      @(negedge uart_clk);
      w++;
    end
    @(negedge uart_clk);
    cmd_valid = 1'b0;
    chk("accept_ready_busy", {62'd0, cmd_ready, busy}, 64'b01);
    if (hold > 0) begin
      stayed = 1'b1;
      repeat (hold) begin
        @(negedge uart_clk);
        if (tx !== 1'b1) stayed = 1'b0;
      end
      chk("tx_held_by_cts", 64'(stayed), 64'd1);
      cts = 1'b0;
      l = 0;
      while (tx !== 1'b0 && l < 10) begin
        @(negedge uart_clk);
        l++;
      end
      chk("cts_release_lat", 64'(l >= 2 && l <= 3), 64'd1);
    end
    capture_tx(cmd);
    if (kind == 1) begin
      c = 0;
      while (resp_timeout !== 1'b1 && c < TO + 50) begin
        @(negedge uart_clk);
        c++;
      end
      chk("timeout_lat", 64'(c), 64'(TO + 1));
      repeat (4) @(negedge uart_clk);
    end else begin
      repeat (delay) @(negedge uart_clk);
      send_rx(reply, kind == 0);
      repeat (BD) @(negedge uart_clk);
    end
    chk("n_resp_valid", 64'(n_valid - v0), 64'(kind == 0));
    chk("n_frame_err", 64'(n_ferr - f0), 64'(kind == 2));
    chk("n_timeout", 64'(n_to - t0), 64'(kind == 1));
    if (kind == 0) begin
      chk("resp_idx_nib", {56'd0, last_idx, last_nib}, {56'd0, reply});
      model_apply(reply);
    end
    chk("snap_vs_model", 64'(dut_snap()), 64'(model_snap()));
    chk("idle_ready_busy", {62'd0, cmd_ready, busy}, 64'b10);
  endtask

  initial begin
    vecs[0]  = '{8'h80, 0, 8'h21, 0,   {4'h0, 4'h0, 8'h01, 16'hffff, 16'hffff}};
    vecs[1]  = '{8'h81, 0, 8'h4D, 100, {4'h0, 4'h0, 8'h01, 16'hfffd, 16'hffff}};
    vecs[2]  = '{8'h82, 0, 8'h5C, 0,   {4'h0, 4'h0, 8'h01, 16'hffcd, 16'hffff}};
    vecs[3]  = '{8'h83, 0, 8'h6B, 0,   {4'h0, 4'h0, 8'h01, 16'hfbcd, 16'hffff}};
    vecs[4]  = '{8'h84, 0, 8'h7A, 0,   {4'h0, 4'h0, 8'h01, 16'habcd, 16'hffff}};
    vecs[5]  = '{8'h85, 0, 8'hF3, 0,   {4'h0, 4'h0, 8'h01, 16'habcd, 16'hffff}};
    vecs[6]  = '{8'h86, 1, 8'h00, 0,   {4'h0, 4'h0, 8'h01, 16'habcd, 16'hffff}};
    vecs[7]  = '{8'h87, 2, 8'h95, 0,   {4'h0, 4'h0, 8'h01, 16'habcd, 16'hffff}};
    vecs[8]  = '{8'h88, 0, 8'h87, 0,   {4'h0, 4'h0, 8'h01, 16'habcd, 16'hfff7}};
    vecs[9]  = '{8'h89, 0, 8'h1A, 5,   {4'h0, 4'hA, 8'h01, 16'habcd, 16'hfff7}};
    vecs[10] = '{8'h8A, 0, 8'h09, 0,   {4'h9, 4'hA, 8'h01, 16'habcd, 16'hfff7}};
    vecs[11] = '{8'h8B, 0, 8'h3E, 0,   {4'h9, 4'hA, 8'hE1, 16'habcd, 16'hfff7}};

    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_data = '0;
    rx = 1'b1;
    cts = 1'b0;
    model_reset();
    repeat (3) @(negedge uart_clk);
    chk("rst_tx_ready_busy", {61'd0, tx, cmd_ready, busy}, 64'b110);
    chk("rst_pulses", {61'd0, resp_valid, resp_timeout, frame_err}, 64'd0);
    chk("rst_idx_nib", {56'd0, resp_idx, resp_nib}, 64'd0);
    chk("rst_snap", 64'(dut_snap()), {16'd0, 4'h0, 4'h0, 8'h00, 16'hffff, 16'hffff});
    reset = 1'b0;
    repeat (2) @(negedge uart_clk);

    // directed table
    for (int i = 0; i < 12; i++) begin
      run_txn(vecs[i].cmd, vecs[i].kind, vecs[i].reply, vecs[i].hold, 3 + i);
      chk("tbl_snap", 64'(dut_snap()), 64'(vecs[i].exp_snap));
    end

    // stray byte while idle: discarded, frame_err once, no reply
    begin
      int v0, f0;
      v0 = n_valid; f0 = n_ferr;
      send_rx(8'h5A, 1'b1);
      repeat (BD) @(negedge uart_clk);
      chk("stray_ferr", 64'(n_ferr - f0), 64'd1);
      chk("stray_no_valid", 64'(n_valid - v0), 64'd0);
      chk("stray_snap", 64'(dut_snap()), 64'(model_snap()));
      chk("stray_ready", 64'(cmd_ready), 64'd1);
    end

    // reset during a data bit: tx must rise without waiting for a clock
    begin
      int w;
      @(negedge uart_clk);
      cmd_valid = 1'b1;
      cmd_data = 8'hC3;
      @(negedge uart_clk);
      cmd_valid = 1'b0;
      w = 0;
      while (tx !== 1'b0 && w < 100) begin
        @(negedge uart_clk);
        w++;
      end
      repeat (3 * BD + BD / 2) @(negedge uart_clk);
      chk("pre_reset_tx_bit2", 64'(tx), 64'd0);
      #2 reset = 1'b1;
      #1 chk("async_reset_tx", 64'(tx), 64'd1);
      model_reset();
      @(negedge uart_clk);
      chk("reset_snap", 64'(dut_snap()), 64'(model_snap()));
      chk("reset_ready_busy", {62'd0, cmd_ready, busy}, 64'b10);
      reset = 1'b0;
      repeat (2) @(negedge uart_clk);
      run_txn(8'hC3, 0, 8'h25, 0, 3);
    end

    // randomized transactions against the model
    for (int i = 0; i < 16; i++) begin
      int k, kind, hold;
      k = $urandom_range(0, 9);
      kind = (k < 7) ? 0 : ((k == 7) ? 1 : 2);
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : 0;
      run_txn(8'($urandom), kind, 8'($urandom), hold, $urandom_range(0, 40));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    failures++;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
